xif_issue_queue: RTL and testbench
==================================

Name: xif_issue_queue

Overview:
- Coprocessor-side consumer of the CV-X-IF issue channel that the CPU drives.
- Decodes each offered instruction and answers issue_ready and issue_resp (accept, writeback) in the handshake cycle.
- Stores accepted instructions, with their operands and immediates, in a DEPTH-entry FIFO.
- Presents stored entries in order to the TCA execution unit over a valid/ready port.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >=2.
- XLEN, 32: operand width.
- X_NUM_RS, 3: register operands per issue request.
- X_ID_WIDTH, 4: instruction id width.
- X_IMM32_OPS, 4: 32-bit immediate operands per request.
- OPCODE, 7'h0B: major opcode owned by this coprocessor (custom-0).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- issue_valid_i  in  1  CPU offers an issue request.
- issue_ready_o  out  1  request consumed this cycle.
- issue_instr_i  in  32  offered instruction.
- issue_id_i  in  X_ID_WIDTH  instruction id.
- issue_rs_i  in  X_NUM_RS*XLEN  packed register operands; rs[i] at bits [i*XLEN +: XLEN].
- issue_rs_valid_i  in  X_NUM_RS  per-operand valid.
- issue_imm32_i  in  X_IMM32_OPS*32  packed immediates.
- issue_imm32_valid_i  in  X_IMM32_OPS  per-immediate valid.
- issue_resp_accept_o  out  1  coprocessor accepts the instruction.
- issue_resp_writeback_o  out  1  accepted instruction will write rd.
- exe_valid_o  out  1  FIFO head valid.
- exe_ready_i  in  1  execution unit takes the head.
- exe_instr_o  out  32  head instruction.
- exe_id_o  out  X_ID_WIDTH  head id.
- exe_rs_o  out  X_NUM_RS*XLEN  head register operands.
- exe_imm32_o  out  X_IMM32_OPS*32  head immediates.
- exe_writeback_o  out  1  head will write back.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- accepted_cnt_o  out  16  accepted-instruction counter; wraps 0xFFFF->0.

Behaviour:
- Reset (async, while rst_i=1): count, read/write pointers and accepted_cnt_o = 0; exe_valid_o = 0. All comb outputs reflect the empty state. Reset mid-operation discards every entry.
- Decode (combinational on issue_instr_i):
  - match = (instr[6:0]==OPCODE).
  - Required register operands: rs[0] and rs[1] always; rs[2] as well when instr[14] (funct3[2]) = 1.
  - Immediates: all X_IMM32_OPS required when instr[14:12]=3'b111.
  - ops_ok = AND of the valid bits of every required operand.
- issue_ready_o:
  - Non-match: 1 whenever issue_valid_i=1, regardless of operand valids or fullness.
  - Match: issue_valid_i & ops_ok & (count<DEPTH).
  - No combinational path from exe_ready_i; a full queue stalls even when a pop occurs that cycle.
- Response: valid only in the handshake cycle (issue_valid_i & issue_ready_o); 0 otherwise.
  - issue_resp_accept_o = match.
  - issue_resp_writeback_o = match & (instr[11:7]!=0).
- Enqueue: on handshake with match, write {instr, id, rs, imm32, writeback} at wptr. wptr wraps modulo DEPTH. accepted_cnt_o increments. Zero latency from the response to storage; the entry is visible at exe_* the next cycle at the earliest.
- Dequeue: exe_valid_o = (count!=0). exe_* are driven from the entry at rptr (registered storage, no bypass). On exe_valid_o & exe_ready_i, rptr advances, wrapping modulo DEPTH.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Empty: exe_ready_i is ignored.
- Request held with ready=0: the CPU may change operand valids; the queue re-evaluates every cycle and takes no state action.
- exe_* data while exe_valid_o=0: don't-care; the bench must not check it.

Test Plan:
- Reset, then issue 0x0020828B (rd=5, funct3=0), id=3, rs_valid=3'b011 -> ready=1, accept=1, writeback=1 the same cycle. Next cycle exe_valid_o=1, exe_id_o=3, count_o=1, accepted_cnt_o=1.
- Issue 0x00000033 (non-match) with rs_valid=0 -> ready=1, accept=0, writeback=0; count_o stays unchanged.
- Issue 0x0020C28B (funct3=4) with rs_valid=3'b011 for 3 cycles, then 3'b111 -> ready=0 for 3 cycles, then ready=1 and accept=1.
- Issue 0x0020F00B (funct3=7, rd=0) with imm32_valid=4'b0111, then 4'b1111 -> ready=0, then ready=1 with accept=1 and writeback=0.
- exe_ready_i=0; issue 5 matching requests with ids 0..4 -> first 4 accepted (count_o=4); 5th held at ready=0. Set exe_ready_i=1 -> pops return ids 0,1,2,3 in order; id 4 is accepted the cycle after count drops to 3.
- Fill 2 entries; assert rst_i asynchronously mid-cycle -> exe_valid_o=0, count_o=0 and accepted_cnt_o=0 immediately. After release, the first accepted id appears at the head.

Source files
------------

// File: rtl/xif_issue_queue.sv
// CV-X-IF issue-channel consumer: decodes offered instructions, answers the
// handshake combinationally and queues accepted ones for the execution unit.
module xif_issue_queue #(
    parameter int         DEPTH       = 4,
    parameter int         XLEN        = 32,
    parameter int         X_NUM_RS    = 3,
    parameter int         X_ID_WIDTH  = 4,
    parameter int         X_IMM32_OPS = 4,
    parameter logic [6:0] OPCODE      = 7'h0B
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [31:0]                   issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]         issue_id_i,
    input  logic [X_NUM_RS*XLEN-1:0]      issue_rs_i,
    input  logic [X_NUM_RS-1:0]           issue_rs_valid_i,
    input  logic [X_IMM32_OPS*32-1:0]     issue_imm32_i,
    input  logic [X_IMM32_OPS-1:0]        issue_imm32_valid_i,
    output logic                          issue_resp_accept_o,
    output logic                          issue_resp_writeback_o,
    output logic                          exe_valid_o,
    input  logic                          exe_ready_i,
    output logic [31:0]                   exe_instr_o,
    output logic [X_ID_WIDTH-1:0]         exe_id_o,
    output logic [X_NUM_RS*XLEN-1:0]      exe_rs_o,
    output logic [X_IMM32_OPS*32-1:0]     exe_imm32_o,
    output logic                          exe_writeback_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [15:0]                   accepted_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  wptr_reg, rptr_reg;
    logic [CW-1:0]  count_reg, count_next;
    logic [15:0]    acc_cnt_reg;

    logic [31:0]               instr_mem [DEPTH];
    logic [X_ID_WIDTH-1:0]     id_mem    [DEPTH];
    logic [X_NUM_RS*XLEN-1:0]  rs_mem    [DEPTH];
    logic [X_IMM32_OPS*32-1:0] imm_mem   [DEPTH];
    logic                      wb_mem    [DEPTH];

    logic [X_NUM_RS-1:0]    rs_req;
    logic [X_IMM32_OPS-1:0] imm_req;
    logic match, ops_ok, full, wb_dec, handshake, push, pop;

    // rs0/rs1 always needed; rs2 only for funct3[2]=1 (three-source forms)
    generate
        for (genvar gi = 0; gi < X_NUM_RS; gi++) begin : g_rs_req
            if (gi < 2) begin : g_always
                assign rs_req[gi] = 1'b1;
            end else if (gi == 2) begin : g_rs2
                assign rs_req[gi] = issue_instr_i[14];
            end else begin : g_unused
                assign rs_req[gi] = 1'b0;
            end
        end
    endgenerate

    assign imm_req   = {X_IMM32_OPS{issue_instr_i[14:12] == 3'b111}};
    assign match     = (issue_instr_i[6:0] == OPCODE);
    assign ops_ok    = (&(~rs_req | issue_rs_valid_i)) & (&(~imm_req | issue_imm32_valid_i));
    assign full      = (count_reg == CW'(DEPTH));
    assign wb_dec    = (issue_instr_i[11:7] != 5'd0);

    // Foreign instructions are consumed immediately so the CPU never stalls on them
    assign issue_ready_o          = issue_valid_i & (~match | (ops_ok & ~full));
    assign handshake              = issue_valid_i & issue_ready_o;
    assign issue_resp_accept_o    = handshake & match;
    assign issue_resp_writeback_o = handshake & match & wb_dec;

    assign push = handshake & match;
    assign pop  = exe_valid_o & exe_ready_i;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            acc_cnt_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wptr_reg    <= wptr_reg + PW'(1);
                acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + PW'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wptr_reg] <= issue_instr_i;
            id_mem[wptr_reg]    <= issue_id_i;
            rs_mem[wptr_reg]    <= issue_rs_i;
            imm_mem[wptr_reg]   <= issue_imm32_i;
            wb_mem[wptr_reg]    <= wb_dec;
        end
    end

    assign exe_valid_o     = (count_reg != '0);
    assign exe_instr_o     = instr_mem[rptr_reg];
    assign exe_id_o        = id_mem[rptr_reg];
    assign exe_rs_o        = rs_mem[rptr_reg];
    assign exe_imm32_o     = imm_mem[rptr_reg];
    assign exe_writeback_o = wb_mem[rptr_reg];
    assign count_o         = count_reg;
    assign accepted_cnt_o  = acc_cnt_reg;

endmodule

// File: tb/tb_xif_issue_queue.sv
// Directed bench for xif_issue_queue: scoreboard of accepted entries checked
// against the queue head every cycle and consumed on each pop.
module tb_xif_issue_queue;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         issue_valid_i = 1'b0;
    logic         issue_ready_o;
    logic [31:0]  issue_instr_i = '0;
    logic [3:0]   issue_id_i = '0;
    logic [95:0]  issue_rs_i = '0;
    logic [2:0]   issue_rs_valid_i = '0;
    logic [127:0] issue_imm32_i = '0;
    logic [3:0]   issue_imm32_valid_i = '0;
    logic         issue_resp_accept_o;
    logic         issue_resp_writeback_o;
    logic         exe_valid_o;
    logic         exe_ready_i = 1'b0;
    logic [31:0]  exe_instr_o;
    logic [3:0]   exe_id_o;
    logic [95:0]  exe_rs_o;
    logic [127:0] exe_imm32_o;
    logic         exe_writeback_o;
    logic [2:0]   count_o;
    logic [15:0]  accepted_cnt_o;

    xif_issue_queue dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
        .issue_imm32_i(issue_imm32_i), .issue_imm32_valid_i(issue_imm32_valid_i),
        .issue_resp_accept_o(issue_resp_accept_o),
        .issue_resp_writeback_o(issue_resp_writeback_o),
        .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
        .exe_instr_o(exe_instr_o), .exe_id_o(exe_id_o),
        .exe_rs_o(exe_rs_o), .exe_imm32_o(exe_imm32_o),
        .exe_writeback_o(exe_writeback_o),
        .count_o(count_o), .accepted_cnt_o(accepted_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]  instr;
        logic [3:0]   id;
        logic [95:0]  rs;
        logic [127:0] imm;
        logic         wb;
    } ent_t;

    ent_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   mcount = 0;
    int   macc = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [3:0] id,
                         input logic [2:0] rsv, input logic [3:0] immv);
        issue_valid_i       = v;
        issue_instr_i       = instr;
        issue_id_i          = id;
        issue_rs_i          = {$urandom, $urandom, $urandom};
        issue_imm32_i       = {$urandom, $urandom, $urandom, $urandom};
        issue_rs_valid_i    = rsv;
        issue_imm32_valid_i = immv;
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic step(input string tag, input logic er, input logic ea, input logic ew);
        ent_t e;
        bit   pop;
        #2;
        chk({tag, " ready"}, issue_ready_o, er);
        chk({tag, " accept"}, issue_resp_accept_o, ea);
        chk({tag, " wb"}, issue_resp_writeback_o, ew);
        chk({tag, " exe_valid"}, exe_valid_o, mcount != 0);
        chk({tag, " count"}, count_o, mcount);
        chk({tag, " acc_cnt"}, accepted_cnt_o, macc);
        pop = 0;
        if (sb.size() != 0) begin
            chk({tag, " head_id"}, exe_id_o, sb[0].id);
            chk({tag, " head_instr"}, exe_instr_o, sb[0].instr);
            chk({tag, " head_rs"}, exe_rs_o, sb[0].rs);
            chk({tag, " head_imm"}, exe_imm32_o, sb[0].imm);
            chk({tag, " head_wb"}, exe_writeback_o, sb[0].wb);
            pop = exe_ready_i;
        end
        if (pop) begin
            void'(sb.pop_front());
            mcount--;
        end
        if (er && ea) begin
            e.instr = issue_instr_i; e.id = issue_id_i; e.rs = issue_rs_i;
            e.imm = issue_imm32_i; e.wb = ew;
            sb.push_back(e);
            mcount++;
            macc++;
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        // Reset state while rst_i held
        #3;
        chk("rst exe_valid", exe_valid_o, 1'b0);
        chk("rst count", count_o, 0);
        chk("rst acc_cnt", accepted_cnt_o, 0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Basic accept with writeback to rd=5
        drive(1, 32'h0020828B, 4'd3, 3'b011, 4'b0000);
        step("t1 issue", 1, 1, 1);
        drive(0, 32'h0, 4'd0, 3'b000, 4'b0000);
        step("t1 after", 0, 0, 0);

        // Foreign opcode consumed without operands
        drive(1, 32'h00000033, 4'd9, 3'b000, 4'b0000);
        step("t2 foreign", 1, 0, 0);

        // funct3=4 needs rs2
        drive(1, 32'h0020C28B, 4'd5, 3'b011, 4'b0000);
        step("t3 wait0", 0, 0, 0);
        drive(1, 32'h0020C28B, 4'd5, 3'b011, 4'b0000);
        step("t3 wait1", 0, 0, 0);
        drive(1, 32'h0020C28B, 4'd5, 3'b011, 4'b0000);
        step("t3 wait2", 0, 0, 0);
        drive(1, 32'h0020C28B, 4'd5, 3'b111, 4'b0000);
        step("t3 go", 1, 1, 1);

        // funct3=7 needs all immediates (and rs2); rd=0 so no writeback
        drive(1, 32'h0020F00B, 4'd6, 3'b111, 4'b0111);
        step("t4 wait", 0, 0, 0);
        drive(1, 32'h0020F00B, 4'd6, 3'b111, 4'b1111);
        step("t4 go", 1, 1, 0);

        // Drain three entries in order
        drive(0, 32'h0, 4'd0, 3'b000, 4'b0000);
        exe_ready_i = 1'b1;
        step("drain a", 0, 0, 0);
        step("drain b", 0, 0, 0);
        step("drain c", 0, 0, 0);
        step("drain idle", 0, 0, 0);
        exe_ready_i = 1'b0;

        // Fill to DEPTH, fifth request stalls
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h0020828B, 4'(i), 3'b011, 4'b0000);
            step($sformatf("fill id%0d", i), 1, 1, 1);
        end
        drive(1, 32'h0020828B, 4'd4, 3'b011, 4'b0000);
        step("full hold", 0, 0, 0);
        exe_ready_i = 1'b1;
        step("full pop no bypass", 0, 0, 0);
        step("id4 accept", 1, 1, 1);
        drive(0, 32'h0, 4'd0, 3'b000, 4'b0000);
        for (int i = 0; i < 4; i++) step($sformatf("pop %0d", i), 0, 0, 0);
        step("empty pop ignored", 0, 0, 0);
        exe_ready_i = 1'b0;

        // Async reset mid-cycle discards entries
        drive(1, 32'h0020828B, 4'd10, 3'b011, 4'b0000);
        step("pre-rst a", 1, 1, 1);
        drive(1, 32'h0020828B, 4'd11, 3'b011, 4'b0000);
        step("pre-rst b", 1, 1, 1);
        drive(0, 32'h0, 4'd0, 3'b000, 4'b0000);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async exe_valid", exe_valid_o, 1'b0);
        chk("async count", count_o, 0);
        chk("async acc_cnt", accepted_cnt_o, 0);
        sb.delete();
        mcount = 0;
        macc = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive(1, 32'h0020828B, 4'd7, 3'b011, 4'b0000);
        step("post-rst issue", 1, 1, 1);
        drive(0, 32'h0, 4'd0, 3'b000, 4'b0000);
        step("post-rst head", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
